// File: rtl/fetch_queue.sv
// fetch_queue
//   In-order instruction fetch queue between fetch and decode.
//   - Accepts one {PC, instruction} pair per cycle from fetch.
//   - Buffers up to DEPTH pairs in a circular buffer.
//   - Presents the oldest pair to decode under a valid/ready handshake.
//   - In_Ready doubles as the PC register advance enable.
//   - Flush drops every buffered (wrong-path) entry on a redirect.
//
// Ports
//   CLK          rising-edge clock
//   Reset        asynchronous active-low reset
//   In_Valid     fetch presents a pair this cycle
//   In_PC        PC of the fetched instruction
//   In_Instr     fetched instruction word
//   In_Ready     queue can accept (Count != DEPTH)
//   Flush        synchronous discard of all entries, overrides push/pop
//   Out_Valid    head entry valid (Count != 0)
//   Out_PC       PC of the head entry (0 when empty)
//   Out_Instr    instruction of the head entry (NOP when empty)
//   Out_PC_Plus4 Out_PC + 4, modulo 2^XLEN
//   Out_Ready    decode consumes the head this cycle
//   Count        number of occupied entries
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     In_Valid,
  input  logic [XLEN-1:0]          In_PC,
  input  logic [XLEN-1:0]          In_Instr,
  output logic                     In_Ready,
  input  logic                     Flush,
  output logic                     Out_Valid,
  output logic [XLEN-1:0]          Out_PC,
  output logic [XLEN-1:0]          Out_Instr,
  output logic [XLEN-1:0]          Out_PC_Plus4,
  input  logic                     Out_Ready,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  // Entry storage carries data only; it is never reset or cleared.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  logic push;
  logic pop;

  assign In_Ready  = (cnt != CW'(DEPTH));
  assign Out_Valid = (cnt != '0);

  // Flush wins over both handshakes, so neither pointer moves in a flush cycle
  // except through the flush reset itself.
  assign push = In_Valid  && In_Ready  && !Flush;
  assign pop  = Out_Valid && Out_Ready && !Flush;

  // Empty queue presents a NOP at PC 0 so decode never sees stale storage.
  always_comb begin
    Out_PC    = '0;
    Out_Instr = NOP_INSTR;
    if (Out_Valid) begin
      Out_PC    = pc_mem[rd_ptr];
      Out_Instr = instr_mem[rd_ptr];
    end
  end

  assign Out_PC_Plus4 = Out_PC + XLEN'(4);
  assign Count        = cnt;

  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]    <= In_PC;
      instr_mem[wr_ptr] <= In_Instr;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              In_Valid;
  logic [XLEN-1:0]   In_PC;
  logic [XLEN-1:0]   In_Instr;
  logic              In_Ready;
  logic              Flush;
  logic              Out_Valid;
  logic [XLEN-1:0]   Out_PC;
  logic [XLEN-1:0]   Out_Instr;
  logic [XLEN-1:0]   Out_PC_Plus4;
  logic              Out_Ready;
  logic [2:0]        Count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .In_Valid     (In_Valid),
    .In_PC        (In_PC),
    .In_Instr     (In_Instr),
    .In_Ready     (In_Ready),
    .Flush        (Flush),
    .Out_Valid    (Out_Valid),
    .Out_PC       (Out_PC),
    .Out_Instr    (Out_Instr),
    .Out_PC_Plus4 (Out_PC_Plus4),
    .Out_Ready    (Out_Ready),
    .Count        (Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: checks the visible state against the model,
  // drives one cycle of stimulus, updates the model, and returns at the next
  // falling edge.
  task automatic tick(input logic iv, input logic [31:0] pc, input logic ordy,
                      input logic fl);
    logic [31:0] ins;
    logic        psh, pp;
    ent_t        e;
    ins = pc ^ 32'h5A00_0033 ^ {$urandom_range(0, 255), 24'h0};
    chk("count",     32'(Count),     32'(sb.size()));
    chk("out_valid", 32'(Out_Valid), 32'(sb.size() != 0));
    chk("in_ready",  32'(In_Ready),  32'(sb.size() != DEPTH));
    if (sb.size() != 0) begin
      chk("out_pc",    Out_PC,       sb[0].pc);
      chk("out_instr", Out_Instr,    sb[0].ins);
      chk("out_pc4",   Out_PC_Plus4, sb[0].pc + 32'd4);
    end else begin
      chk("empty_pc",    Out_PC,       32'h0);
      chk("empty_instr", Out_Instr,    NOP);
      chk("empty_pc4",   Out_PC_Plus4, 32'h4);
    end
    In_Valid  = iv;
    In_PC     = pc;
    In_Instr  = ins;
    Out_Ready = ordy;
    Flush     = fl;
    psh = iv && (sb.size() != DEPTH) && !fl;
    pp  = ordy && (sb.size() != 0) && !fl;
    if (fl) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (psh) begin
        e.pc  = pc;
        e.ins = ins;
        sb.push_back(e);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    Reset = 1'b0; In_Valid = 1'b0; In_PC = '0; In_Instr = '0;
    Flush = 1'b0; Out_Ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_count",     32'(Count),     32'd0);
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_in_ready",  32'(In_Ready),  32'd1);
    chk("rst_instr",     Out_Instr,      NOP);
    chk("rst_pc4",       Out_PC_Plus4,   32'h4);
    Reset = 1'b1;
    @(negedge CLK);

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) tick(1'b1, 32'(i * 4), 1'b0, 1'b0);
    chk("full_in_ready", 32'(In_Ready), 32'd0);
    chk("full_head_pc",  Out_PC,        32'h0);
    chk("full_head_pc4", Out_PC_Plus4,  32'h4);

    // Full plus pop: push rejected, fetch re-presents it next cycle.
    tick(1'b1, 32'h10, 1'b1, 1'b0);
    chk("fullpop_count", 32'(Count), 32'd3);
    tick(1'b1, 32'h10, 1'b0, 1'b0);

    // Drain in order, then empty NOP.
    for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_instr", Out_Instr, NOP);

    // Streaming with pointer wrap.
    for (int i = 0; i < 10; i++) tick(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
    chk("stream_count", 32'(Count), 32'd1);
    tick(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush together with a push and a pop.
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h180 + 32'(i * 4), 1'b0, 1'b0);
    tick(1'b1, 32'h300, 1'b1, 1'b1);
    chk("flush_count",    32'(Count),     32'd0);
    chk("flush_valid",    32'(Out_Valid), 32'd0);
    chk("flush_in_ready", 32'(In_Ready),  32'd1);
    tick(1'b1, 32'h200, 1'b0, 1'b0);
    chk("redirect_pc", Out_PC, 32'h200);
    tick(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++)
      tick(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries held.
    tick(1'b1, 32'h400, 1'b0, 1'b0);
    tick(1'b1, 32'h404, 1'b0, 1'b0);
    chk("pre_arst_count", 32'(Count), 32'd2);
    In_Valid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("arst_count",    32'(Count),     32'd0);
    chk("arst_valid",    32'(Out_Valid), 32'd0);
    chk("arst_in_ready", 32'(In_Ready),  32'd1);
    chk("arst_instr",    Out_Instr,      NOP);
    sb.delete();
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    tick(1'b1, 32'h500, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
